fp_compare: RTL and testbench
=============================

# fp_compare

Single-precision floating-point comparator that implements `feq`, `flt` and `fle` with RISC-V semantics. It is the responder on the FPU's stb/ack operand/result protocol, the same protocol the FPU controller uses to drive the adder. The controller presents `in1`/`in2` with strobes and collects `out` when `out_stb` is high. This block accepts operand A, then operand B, computes the compare, and holds the result until it is acknowledged.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  reset; synchronous, active-low.
- `op`  in  2  compare select, sampled with operand A: `00` = feq, `01` = flt, `10` = fle, `11` = reserved.
- `input_a`  in  32  operand A, IEEE-754 binary32.
- `input_a_stb`  in  1  operand A valid.
- `input_a_ack`  out  1  ready to take operand A.
- `input_b`  in  32  operand B, IEEE-754 binary32.
- `input_b_stb`  in  1  operand B valid.
- `input_b_ack`  out  1  ready to take operand B.
- `output_z`  out  32  result: `32'h1` if the compare is true, otherwise `32'h0`.
- `output_nv`  out  1  invalid-operation flag, valid with `output_z`.
- `output_z_stb`  out  1  result valid.
- `output_z_ack`  in  1  result consumed.

## Operation
- States: `GET_A` → `GET_B` → `CMP` → `PUT_Z` → `GET_A`.
- **GET_A**: `input_a_ack` = 1. When `input_a_stb` and `input_a_ack` are both high at a rising edge:
  - latch `input_a` and `op`;
  - go to `GET_B`.
- **GET_B**: `input_b_ack` = 1. When `input_b_stb` is high at a rising edge, latch `input_b` and go to `CMP`.
- **CMP**: one cycle.
  - Classify both operands: NaN (exp = FF, mant ≠ 0), sNaN (NaN with mant[22] = 0), zero (exp = 0, mant = 0).
  - Register `output_z` and `output_nv`, then go to `PUT_Z`.
- **PUT_Z**: `output_z_stb` = 1. When `output_z_ack` is high at a rising edge, go to `GET_A`.
- Ack and stb outputs are Moore decodes of the state. Each is high only in its own state.
- Compare rules:
  - Either operand NaN: result 0.
  - Otherwise +0 and −0 compare equal.
  - Ordering uses sign-magnitude: equal signs compare magnitudes, with the order inverted when both are negative. Unequal signs: the negative operand is smaller unless both are zero.
- `output_nv`:
  - feq: set only if either operand is an sNaN.
  - flt/fle: set if either operand is any NaN.
- Reserved op: `output_z` = 0, `output_nv` = 0.
- `op`, `input_a` and `input_b` changes outside their accept edges are ignored.
- `output_z` and `output_nv` are stable for the whole time `output_z_stb` is high.

## Timing
- Reset (`reset_n` low at a rising edge), applied in any state:
  - state = `GET_A`, so `input_a_ack` = 1 after the edge;
  - `input_b_ack` = 0, `output_z_stb` = 0, `output_z` = 0, `output_nv` = 0;
  - latched operands are discarded.
- Reset mid-transaction drops any pending result. The initiator must restart.
- Minimum transaction, edges E0–E3 with no stalls:
  - E0: A accepted.
  - E1: B accepted.
  - E2: result registered; `output_z_stb` high after E2.
  - E3: `output_z_ack` sampled; `input_a_ack` high after E3.
  - Turnaround is 4 cycles.
- Strobes held low stall the FSM in `GET_A` or `GET_B` indefinitely. Acks stay high while stalled.
- `output_z_ack` held low keeps the FSM in `PUT_Z` indefinitely.
- `output_z_ack` high outside `PUT_Z` is ignored.
- Simultaneous `input_a_stb` and `input_b_stb` in `GET_A`: only A is taken. B is taken in `GET_B` at the next edge if its strobe is still high.

## Structure
- Shared package `fpu_pkg` holds:
  - the `fcmp_state_t` enum;
  - the compare-op constants `FCMP_EQ`, `FCMP_LT`, `FCMP_LE`;
  - the binary32 field widths and the `EXP_MAX` constant.
- Sub-module `fp_classify` (combinational, binary32 in; `is_nan`, `is_snan`, `is_zero` out) is instantiated twice, once per operand.
- Estimated size: ~150 lines of RTL.

## Test plan
- feq 0x3F800000 vs 0x3F800000 → `output_z` = 1, `output_nv` = 0. Transaction completes in 4 cycles from the A-accept edge.
- +0 (0x00000000) vs −0 (0x80000000): feq → 1, flt → 0, fle → 1. `output_nv` = 0 in all three.
- flt −2.0 (0xC0000000) vs 1.0 (0x3F800000) → 1. Operands swapped → 0. fle −2.0 vs −2.0 → 1.
- qNaN 0x7FC00000 vs 1.0: feq → z = 0, nv = 0; flt → z = 0, nv = 1. sNaN 0x7F800001 with feq → z = 0, nv = 1.
- Backpressure: hold `output_z_ack` low for 5 cycles. `output_z_stb` stays high with z and nv unchanged, and the FSM returns to `GET_A` one edge after ack.
- `reset_n` low for one edge while in `GET_B` → `input_b_ack` = 0 and `input_a_ack` = 1 after that edge. A following full transaction returns the correct result.

Source files
------------

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU types and binary32 constants
package fpu_pkg;

  typedef enum logic [1:0] {
    ST_GET_A = 2'd0,
    ST_GET_B = 2'd1,
    ST_CMP   = 2'd2,
    ST_PUT_Z = 2'd3
  } fcmp_state_t;

  localparam logic [1:0] FCMP_EQ = 2'b00;
  localparam logic [1:0] FCMP_LT = 2'b01;
  localparam logic [1:0] FCMP_LE = 2'b10;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational binary32 NaN/sNaN/zero classifier
module fp_classify
  import fpu_pkg::*;
(
  input  logic [31:0] x,
  output logic        is_nan,
  output logic        is_snan,
  output logic        is_zero
);

  logic [EXP_W-1:0]  exp_f;
  logic [MANT_W-1:0] mant_f;
  logic              unused_sign;

  assign exp_f       = x[30:23];
  assign mant_f      = x[22:0];
  assign unused_sign = x[31];

  // Quiet bit is the mantissa MSB; a NaN with it clear is signalling.
  assign is_nan  = (exp_f == EXP_MAX) && (mant_f != '0);
  assign is_snan = is_nan && !mant_f[MANT_W-1];
  assign is_zero = (exp_f == '0) && (mant_f == '0);

endmodule

// File: rtl/fp_compare.sv
// rtl/fp_compare.sv - binary32 feq/flt/fle comparator on the stb/ack protocol
module fp_compare
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  op,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_nv,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  fcmp_state_t state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic        z_q, z_d, nv_q, nv_d;

  logic a_nan, a_snan, a_zero;
  logic b_nan, b_snan, b_zero;
  logic any_nan, both_zero, is_eq, is_lt;

  fp_classify u_class_a (.x(a_q), .is_nan(a_nan), .is_snan(a_snan), .is_zero(a_zero));
  fp_classify u_class_b (.x(b_q), .is_nan(b_nan), .is_snan(b_snan), .is_zero(b_zero));

  assign input_a_ack  = (state_q == ST_GET_A);
  assign input_b_ack  = (state_q == ST_GET_B);
  assign output_z_stb = (state_q == ST_PUT_Z);
  assign output_z     = {31'd0, z_q};
  assign output_nv    = nv_q;

  // Sign-magnitude ordering; both-negative inverts the magnitude compare.
  always_comb begin
    any_nan   = a_nan || b_nan;
    both_zero = a_zero && b_zero;
    is_eq     = both_zero || (a_q == b_q);
    is_lt     = 1'b0;
    if (!both_zero) begin
      if (a_q[31] != b_q[31])
        is_lt = a_q[31];
      else if (!a_q[31])
        is_lt = a_q[30:0] < b_q[30:0];
      else
        is_lt = a_q[30:0] > b_q[30:0];
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    z_d     = z_q;
    nv_d    = nv_q;
    case (state_q)
      ST_GET_A: if (input_a_stb) begin
        a_d     = input_a;
        op_d    = op;
        state_d = ST_GET_B;
      end
      ST_GET_B: if (input_b_stb) begin
        b_d     = input_b;
        state_d = ST_CMP;
      end
      ST_CMP: begin
        case (op_q)
          FCMP_EQ: begin
            z_d  = !any_nan && is_eq;
            nv_d = a_snan || b_snan;
          end
          FCMP_LT: begin
            z_d  = !any_nan && is_lt;
            nv_d = any_nan;
          end
          FCMP_LE: begin
            z_d  = !any_nan && (is_lt || is_eq);
            nv_d = any_nan;
          end
          default: begin
            z_d  = 1'b0;
            nv_d = 1'b0;
          end
        endcase
        state_d = ST_PUT_Z;
      end
      ST_PUT_Z: if (output_z_ack) state_d = ST_GET_A;
      default: state_d = ST_GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_GET_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      z_q     <= 1'b0;
      nv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      z_q     <= z_d;
      nv_q    <= nv_d;
    end
  end

endmodule

// File: tb/tb_fp_compare.sv
// tb/tb_fp_compare.sv - directed self-checking bench for fp_compare
module tb_fp_compare;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  op;
  logic [31:0] input_a, input_b, output_z;
  logic        input_a_stb, input_a_ack, input_b_stb, input_b_ack;
  logic        output_nv, output_z_stb, output_z_ack;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] ONE   = 32'h3F800000;
  localparam logic [31:0] M_ONE = 32'hBF800000;
  localparam logic [31:0] M_TWO = 32'hC0000000;
  localparam logic [31:0] P_ZER = 32'h00000000;
  localparam logic [31:0] M_ZER = 32'h80000000;
  localparam logic [31:0] QNAN  = 32'h7FC00000;
  localparam logic [31:0] SNAN  = 32'h7F800001;

  fp_compare dut (
    .clk(clk), .reset_n(reset_n), .op(op),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
    .output_z(output_z), .output_nv(output_nv),
    .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full no-stall transaction; inputs are scrambled after each accept edge.
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic ez, input logic env);
    chk({tag, "_a_ack"}, {31'd0, input_a_ack}, 32'd1);
    op = o; input_a = a; input_a_stb = 1'b1;
    tick();
    input_a_stb = 1'b0; op = 2'b11; input_a = 32'hDEADBEEF;
    input_b = b; input_b_stb = 1'b1;
    tick();
    input_b_stb = 1'b0; input_b = 32'hDEADBEEF;
    tick();
    chk({tag, "_stb"}, {31'd0, output_z_stb}, 32'd1);
    chk({tag, "_z"}, output_z, {31'd0, ez});
    chk({tag, "_nv"}, {31'd0, output_nv}, {31'd0, env});
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
    chk({tag, "_turn"}, {30'd0, output_z_stb, input_a_ack}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; op = 2'b00; input_a = '0; input_b = '0;
    input_a_stb = 1'b0; input_b_stb = 1'b0; output_z_ack = 1'b1;
    tick(); tick();
    chk("rst_a_ack", {31'd0, input_a_ack}, 32'd1);
    chk("rst_b_ack", {31'd0, input_b_ack}, 32'd0);
    chk("rst_stb", {31'd0, output_z_stb}, 32'd0);
    chk("rst_z", output_z, 32'd0);
    chk("rst_nv", {31'd0, output_nv}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("ack_ignored", {31'd0, input_a_ack}, 32'd1);
    output_z_ack = 1'b0;

    run("feq_one",   2'b00, ONE,   ONE,   1'b1, 1'b0);
    run("feq_zero",  2'b00, P_ZER, M_ZER, 1'b1, 1'b0);
    run("flt_zero",  2'b01, P_ZER, M_ZER, 1'b0, 1'b0);
    run("fle_zero",  2'b10, P_ZER, M_ZER, 1'b1, 1'b0);
    run("flt_m2_1",  2'b01, M_TWO, ONE,   1'b1, 1'b0);
    run("flt_1_m2",  2'b01, ONE,   M_TWO, 1'b0, 1'b0);
    run("fle_m2_m2", 2'b10, M_TWO, M_TWO, 1'b1, 1'b0);
    run("flt_m2_m1", 2'b01, M_TWO, M_ONE, 1'b1, 1'b0);
    run("flt_m1_m2", 2'b01, M_ONE, M_TWO, 1'b0, 1'b0);
    run("feq_qnan",  2'b00, QNAN,  ONE,   1'b0, 1'b0);
    run("flt_qnan",  2'b01, QNAN,  ONE,   1'b0, 1'b1);
    run("feq_snan",  2'b00, SNAN,  ONE,   1'b0, 1'b1);
    run("fle_qnanb", 2'b10, ONE,   QNAN,  1'b0, 1'b1);
    run("rsv_snan",  2'b11, SNAN,  ONE,   1'b0, 1'b0);
    run("feq_ne",    2'b00, ONE,   M_ONE, 1'b0, 1'b0);

    // Simultaneous strobes in GET_A take only A; B follows next edge.
    op = 2'b01; input_a = M_TWO; input_b = ONE;
    input_a_stb = 1'b1; input_b_stb = 1'b1;
    tick();
    input_a_stb = 1'b0;
    chk("sim_b_ack", {31'd0, input_b_ack}, 32'd1);
    chk("sim_a_ack", {31'd0, input_a_ack}, 32'd0);
    tick();
    input_b_stb = 1'b0;
    tick();
    chk("sim_z", output_z, 32'd1);

    // Backpressure: result must hold for 5 stalled cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stb", {31'd0, output_z_stb}, 32'd1);
      chk("bp_z", output_z, 32'd1);
      chk("bp_nv", {31'd0, output_nv}, 32'd0);
    end
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
    chk("bp_a_ack", {31'd0, input_a_ack}, 32'd1);
    chk("bp_stb_lo", {31'd0, output_z_stb}, 32'd0);

    // Reset while waiting for B.
    op = 2'b00; input_a = ONE; input_a_stb = 1'b1;
    tick();
    input_a_stb = 1'b0;
    chk("pre_rst_b_ack", {31'd0, input_b_ack}, 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mid_rst_b_ack", {31'd0, input_b_ack}, 32'd0);
    chk("mid_rst_a_ack", {31'd0, input_a_ack}, 32'd1);
    chk("mid_rst_z", output_z, 32'd0);
    run("post_rst", 2'b10, M_ONE, M_TWO, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
